// File: rtl/cpu_pkg.sv
// Shared CPU address-path defaults, reused by fetch, branch and PC logic.
package cpu_pkg;

    localparam int unsigned CPU_ADDR_WIDTH  = 32;
    localparam logic [31:0] CPU_RESET_ADDR  = 32'h0000_0000;
    localparam int unsigned CPU_INSTR_BYTES = 4;

    typedef logic [CPU_ADDR_WIDTH-1:0] cpu_addr_t;

endpackage

// File: rtl/pc_incrementer.sv
// Modulo-2^WIDTH address adder that also reports carry out of the top bit.
module pc_incrementer #(
    parameter int unsigned WIDTH = cpu_pkg::CPU_ADDR_WIDTH
) (
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    always_comb begin
        {carry, sum} = {1'b0, addr} + {1'b0, step};
    end

endmodule

// File: rtl/program_counter.sv
// PC register with asynchronous reset, plus sequential next-address and status flags.
module program_counter
    import cpu_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = CPU_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = ADDR_WIDTH'(CPU_RESET_ADDR),
    parameter int unsigned           INSTR_BYTES = CPU_INSTR_BYTES
) (
    input  logic                  clock,
    input  logic [ADDR_WIDTH-1:0] pc_in_addr,
    output logic [ADDR_WIDTH-1:0] pc_out_addr,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] pc_plus4_addr,
    output logic                  pc_misaligned,
    output logic                  pc_wrapped
);

    logic [ADDR_WIDTH-1:0] step;

    assign step = ADDR_WIDTH'(INSTR_BYTES);

    // No enable and no masking: the input is taken verbatim every edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_out_addr <= RESET_ADDR;
        end else begin
            pc_out_addr <= pc_in_addr;
        end
    end

    pc_incrementer #(
        .WIDTH (ADDR_WIDTH)
    ) u_incr (
        .addr  (pc_out_addr),
        .step  (step),
        .sum   (pc_plus4_addr),
        .carry (pc_wrapped)
    );

    assign pc_misaligned = (pc_out_addr[1:0] != 2'b00);

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed vectors, reset corners, random loads.
module tb_program_counter;

    logic        clock;
    logic [31:0] pc_in_addr;
    logic [31:0] pc_out_addr;
    logic        reset_n;
    logic [31:0] pc_plus4_addr;
    logic        pc_misaligned;
    logic        pc_wrapped;

    int unsigned total = 0;
    int unsigned bad   = 0;

    program_counter #(
        .ADDR_WIDTH  (32),
        .RESET_ADDR  (32'h0000_0000),
        .INSTR_BYTES (4)
    ) dut (
        .clock         (clock),
        .pc_in_addr    (pc_in_addr),
        .pc_out_addr   (pc_out_addr),
        .reset_n       (reset_n),
        .pc_plus4_addr (pc_plus4_addr),
        .pc_misaligned (pc_misaligned),
        .pc_wrapped    (pc_wrapped)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    typedef struct {
        logic [31:0] in_addr;
        logic [31:0] out_addr;
        logic [31:0] plus4;
        logic        mis;
        logic        wrap;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_out, input logic [31:0] e_p4,
                           input logic e_mis, input logic e_wrap);
        chk({tag, ".out"},   pc_out_addr,           e_out);
        chk({tag, ".plus4"}, pc_plus4_addr,         e_p4);
        chk({tag, ".mis"},   {31'd0, pc_misaligned}, {31'd0, e_mis});
        chk({tag, ".wrap"},  {31'd0, pc_wrapped},    {31'd0, e_wrap});
    endtask

    task automatic load(input logic [31:0] v);
        @(negedge clock);
        pc_in_addr = v;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] model_out;
        logic [63:0] wide;

        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'h0000_0004, 32'h0000_0008, 1'b0, 1'b0};
        vecs[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'h0000_0006, 32'h0000_0006, 32'h0000_000A, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_0008, 32'h0000_0008, 32'h0000_000C, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0000_0002, 1'b1, 1'b1};
        vecs[6] = '{32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[7] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0003, 1'b1, 1'b0};
        vecs[8] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b0, 1'b0};

        reset_n    = 1'b0;
        pc_in_addr = 32'h1234_5678;
        #5;
        chk_all("reset", 32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        chk("reset_hold.out", pc_out_addr, 32'h0000_0000);

        @(negedge clock);
        reset_n    = 1'b1;
        pc_in_addr = 32'h0000_0004;
        #9;
        chk("first_load_pre.out", pc_out_addr, 32'h0000_0000);
        @(posedge clock);
        #1;
        chk("first_load.out", pc_out_addr, 32'h0000_0004);

        for (int i = 0; i < 9; i++) begin
            load(vecs[i].in_addr);
            chk_all($sformatf("vec%0d", i), vecs[i].out_addr, vecs[i].plus4, vecs[i].mis, vecs[i].wrap);
        end

        // Value must hold until the edge that samples the new input.
        load(32'h0000_0000);
        @(negedge clock);
        pc_in_addr = 32'h0000_0004;
        #9;
        chk("hold_pre_edge.out", pc_out_addr, 32'h0000_0000);
        @(posedge clock);
        #1;
        chk("hold_post_edge.out", pc_out_addr, 32'h0000_0004);

        load(32'h0000_0040);
        chk("mid_reset_pre.out", pc_out_addr, 32'h0000_0040);
        @(negedge clock);
        pc_in_addr = 32'h0000_0044;
        #3;
        reset_n = 1'b0;
        #1;
        chk_all("mid_reset", 32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        chk("mid_reset_edge.out", pc_out_addr, 32'h0000_0000);
        @(negedge clock);
        reset_n    = 1'b1;
        pc_in_addr = 32'h0000_0048;
        #5;
        chk("release_pre.out", pc_out_addr, 32'h0000_0000);
        @(posedge clock);
        #1;
        chk("release_load.out", pc_out_addr, 32'h0000_0048);

        for (int n = 0; n < 1000; n++) begin
            v = $urandom;
            if ($urandom_range(0, 7) == 0) v = 32'hFFFF_FFF0 | (v & 32'h0000_000F);
            model_out = v;
            load(v);
            wide = {32'd0, model_out} + 64'd4;
            chk("rand.out",   pc_out_addr,   model_out);
            chk("rand.plus4", pc_plus4_addr, wide[31:0]);
            chk("rand.mis",   {31'd0, pc_misaligned}, {31'd0, (model_out % 4) != 0});
            chk("rand.wrap",  {31'd0, pc_wrapped},    {31'd0, wide >= 64'h1_0000_0000});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of every address port.
REQ-002 Parameter RESET_ADDR, default 32'h00000000: value loaded into the PC on reset.
REQ-003 Parameter INSTR_BYTES, default 4: increment applied to form the sequential next address.
REQ-004 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-005 Port order SHALL be fixed as listed below, so the first three ports may be connected positionally.
REQ-006 clock  input  1  rising-edge clock, sole clock domain.
REQ-007 pc_in_addr  input  ADDR_WIDTH  next PC value, sampled every rising edge.
REQ-008 pc_out_addr  output  ADDR_WIDTH  current PC, registered.
REQ-009 reset_n  input  1  asynchronous active-low reset.
REQ-010 pc_plus4_addr  output  ADDR_WIDTH  pc_out_addr + INSTR_BYTES, combinational.
REQ-011 pc_misaligned  output  1  high when pc_out_addr[1:0] != 2'b00, combinational.
REQ-012 pc_wrapped  output  1  high when the pc_out_addr + INSTR_BYTES addition carries out of ADDR_WIDTH, combinational.

Function
REQ-013 On every rising clock edge with reset_n high, pc_out_addr SHALL load pc_in_addr unmodified; there is no enable or stall.
REQ-014 Latency SHALL be exactly one clock: a value applied before edge N is visible on pc_out_addr after edge N and stays stable until edge N+1.
REQ-015 pc_out_addr SHALL NOT alter the loaded value: no alignment masking and no clamping.
REQ-016 pc_plus4_addr SHALL be modulo 2^ADDR_WIDTH.
- 32'hFFFFFFFC + 4 yields 32'h00000000, with pc_wrapped high.
REQ-017 pc_misaligned SHALL only flag a misaligned PC; it SHALL NOT block the load.
REQ-018 pc_wrapped SHALL be low for every pc_out_addr below 2^ADDR_WIDTH - INSTR_BYTES.
REQ-019 If pc_in_addr contains X or Z bits, pc_out_addr SHALL propagate them; no sanitising.

Reset
REQ-020 While reset_n is low, pc_out_addr SHALL equal RESET_ADDR immediately, independent of clock.
- pc_plus4_addr SHALL equal RESET_ADDR + INSTR_BYTES.
- pc_misaligned and pc_wrapped SHALL be 0 for the default parameters.
REQ-021 Reset asserted mid-operation SHALL override any pending load.
REQ-022 The first load after reset_n rises SHALL occur on the first rising edge at which reset_n is sampled high.
REQ-023 A high or undriven-high reset_n SHALL never disturb normal loading.

Structure
REQ-024 ADDR_WIDTH, RESET_ADDR and INSTR_BYTES defaults SHALL live in a shared package (cpu_pkg) for reuse by fetch and branch logic.
REQ-025 The increment and carry logic SHALL be one sub-module, pc_incrementer, with inputs addr and step and outputs sum and carry.
REQ-026 The PC register itself SHALL be a single always block sensitive to the clock rising edge and the reset_n falling edge.

Verification
REQ-027 Set pc_in_addr=32'h00000000, wait one 20 ns clock -> pc_out_addr=32'h00000000, pc_plus4_addr=32'h00000004.
REQ-028 Set pc_in_addr=32'h00000004, wait one clock -> pc_out_addr=32'h00000004.
- The value SHALL not change before that rising edge.
REQ-029 Drive reset_n low mid-cycle while pc_out_addr=32'h00000040 -> pc_out_addr=32'h00000000 before the next edge.
- Release reset_n -> the next edge loads pc_in_addr.
REQ-030 Set pc_in_addr=32'hFFFFFFFC, one clock -> pc_plus4_addr=32'h00000000, pc_wrapped=1.
REQ-031 Set pc_in_addr=32'h00000006, one clock -> pc_out_addr=32'h00000006, pc_misaligned=1.
- Next load of 32'h00000008 -> pc_misaligned=0.
REQ-032 Drive a random 1000-cycle sequence, checking every cycle: pc_out_addr equals the previous cycle's pc_in_addr, and pc_plus4_addr equals pc_out_addr + 4.
